// File: rtl/bbpd_vote.sv
// rtl/bbpd_vote.sv - Alexander bang-bang phase detector with windowed majority vote
//
// Purpose:
//   Takes one data sample and one edge sample per valid UI. For each data
//   transition it decides whether the recovered clock is early or late. It
//   sums those votes over a window of WIN valid UIs. At the window boundary
//   it emits a single-cycle up/dn pulse for the CDR loop filter.
//   up = clock is late, so the loop filter code must increase.
//
// Ports:
//   clk       in   1   clock
//   rst_n     in   1   asynchronous active-low reset
//   en        in   1   detector enable; low flushes window and history
//   valid     in   1   data/edge_smp carry a new UI this cycle
//   data      in   1   data sample d[k], centre of UI k
//   edge_smp  in   1   edge sample e[k], between UI k-1 and UI k
//   up        out  1   one-cycle pulse: window majority says clock late
//   dn        out  1   one-cycle pulse: window majority says clock early
//   vote      out  CW  signed running vote sum of the current window
//   win_done  out  1   one-cycle pulse at every window boundary

module bbpd_vote #(
    parameter int WIN = 16,
    parameter int THR = 1,
    parameter int CW  = $clog2(WIN) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid,
    input  logic                 data,
    input  logic                 edge_smp,
    output logic                 up,
    output logic                 dn,
    output logic signed [CW-1:0] vote,
    output logic                 win_done
);

    localparam int NW = $clog2(WIN);

    localparam logic [NW-1:0]        LAST_UI = NW'(WIN - 1);
    localparam logic signed [CW-1:0] THR_POS = CW'(THR);
    localparam logic signed [CW-1:0] THR_NEG = -THR_POS;
    localparam logic signed [CW-1:0] V_LATE  = CW'(1);
    localparam logic signed [CW-1:0] V_EARLY = -V_LATE;

    logic [NW-1:0]        count;
    logic                 d_prev;
    logic                 have_prev;
    logic signed [CW-1:0] v;
    logic signed [CW-1:0] s;

    // The edge sample sits between d_prev and data. When the two differ,
    // it must equal one of them. Matching the new bit means the edge was
    // sampled after the real transition, so the clock is late.
    always_comb begin
        v = '0;
        if (have_prev && (d_prev != data)) begin
            v = (edge_smp == data) ? V_LATE : V_EARLY;
        end
        s = vote + v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up        <= 1'b0;
            dn        <= 1'b0;
            win_done  <= 1'b0;
            vote      <= '0;
            count     <= '0;
            d_prev    <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            up       <= 1'b0;
            dn       <= 1'b0;
            win_done <= 1'b0;
            if (!en) begin
                vote      <= '0;
                count     <= '0;
                have_prev <= 1'b0;
            end else if (valid) begin
                d_prev    <= data;
                have_prev <= 1'b1;
                if (count == LAST_UI) begin
                    // The closing UI's vote is folded into the decision.
                    count    <= '0;
                    vote     <= '0;
                    win_done <= 1'b1;
                    up       <= (s >= THR_POS);
                    dn       <= (s <= THR_NEG);
                end else begin
                    count <= count + 1'b1;
                    vote  <= s;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbpd_vote.sv
// tb/tb_bbpd_vote.sv - self-checking bench for bbpd_vote (THR=1 and THR=4 instances)

module tb_bbpd_vote;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic valid = 1'b0;
    logic data = 1'b0;
    logic edge_smp = 1'b0;
    logic up1, dn1, wd1, up4, dn4, wd4;
    logic signed [5:0] vote1, vote4;

    always #5 clk = ~clk;

    bbpd_vote #(.WIN(16), .THR(1)) u_thr1 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .data(data),
        .edge_smp(edge_smp), .up(up1), .dn(dn1), .vote(vote1), .win_done(wd1)
    );

    bbpd_vote #(.WIN(16), .THR(4)) u_thr4 (
        .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .data(data),
        .edge_smp(edge_smp), .up(up4), .dn(dn4), .vote(vote4), .win_done(wd4)
    );

    typedef struct {
        logic [15:0] dat;
        logic [15:0] late;
        int          v15;
        bit          u1, d1, u4, d4;
    } vec_t;

    typedef struct {
        int vote;
        bit wd, u1, d1, u4, d4;
    } exp_t;

    vec_t tbl[8];
    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_vote = 0;
    int m_cnt  = 0;
    bit m_dprev = 1'b0;
    bit m_have  = 1'b0;
    bit pd = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit v, input bit d, input bit es);
        exp_t x;
        int vi;
        int s;
        en = e; valid = v; data = d; edge_smp = es;
        x = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        if (!e) begin
            m_vote = 0; m_cnt = 0; m_have = 1'b0;
        end else if (v) begin
            vi = 0;
            if (m_have && (m_dprev != d)) vi = (es == d) ? 1 : -1;
            m_dprev = d;
            m_have  = 1'b1;
            if (m_cnt == 15) begin
                s = m_vote + vi;
                x.wd = 1'b1;
                x.u1 = (s >= 1);  x.d1 = (s <= -1);
                x.u4 = (s >= 4);  x.d4 = (s <= -4);
                m_vote = 0; m_cnt = 0;
            end else begin
                m_vote = m_vote + vi;
                m_cnt++;
            end
        end
        x.vote = m_vote;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("vote_thr1", int'(vote1), x.vote);
        chk("vote_thr4", int'(vote4), x.vote);
        chk("win_done_thr1", int'(wd1), int'(x.wd));
        chk("win_done_thr4", int'(wd4), int'(x.wd));
        chk("up_thr1", int'(up1), int'(x.u1));
        chk("dn_thr1", int'(dn1), int'(x.d1));
        chk("up_thr4", int'(up4), int'(x.u4));
        chk("dn_thr4", int'(dn4), int'(x.d4));
    endtask

    // One valid UI; late picks edge_smp equal to the new bit, otherwise to the old one.
    task automatic ui(input bit d, input bit late);
        step(1'b1, 1'b1, d, late ? d : pd);
        pd = d;
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        int nup;
        int upidx;

        tbl[0] = '{16'hAAAA, 16'hFFFF,  14, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{16'hAAAA, 16'h0000, -14, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'hAAAA, 16'h03FE,   4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'hAAAA, 16'h00FE,   0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'h5554, 16'h07FC,   5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'h5554, 16'h007C,  -3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'hFFFF,   0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h0000,   0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_vote", int'(vote1), 0);
        chk("rst_up", int'(up1), 0);
        chk("rst_dn", int'(dn1), 0);
        chk("rst_win_done", int'(wd1), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven windows, each starting from a flushed detector
        for (int k = 0; k < 8; k++) begin
            flush();
            for (int i = 0; i < 16; i++) begin
                ui(tbl[k].dat[i], tbl[k].late[i]);
                if (i == 14) chk($sformatf("tbl%0d_vote15", k), int'(vote1), tbl[k].v15);
            end
            chk($sformatf("tbl%0d_win_done", k), int'(wd1), 1);
            chk($sformatf("tbl%0d_up_thr1", k), int'(up1), int'(tbl[k].u1));
            chk($sformatf("tbl%0d_dn_thr1", k), int'(dn1), int'(tbl[k].d1));
            chk($sformatf("tbl%0d_up_thr4", k), int'(up4), int'(tbl[k].u4));
            chk($sformatf("tbl%0d_dn_thr4", k), int'(dn4), int'(tbl[k].d4));
        end

        // Continuous lock: late, late, tie, early windows back to back
        flush();
        for (int i = 0; i < 64; i++) begin
            if (i < 32)      ui(i[0], 1'b1);
            else if (i < 40) ui(i[0], 1'b1);
            else             ui(i[0], 1'b0);
            if (i == 14) chk("lock_w0_vote15", int'(vote1), 14);
            if (i == 15) chk("lock_w0_up", int'(up1), 1);
            if (i == 30) chk("lock_w1_vote15", int'(vote1), 15);
            if (i == 31) chk("lock_w1_up", int'(up1), 1);
            if (i == 47) begin
                chk("tie_win_done", int'(wd1), 1);
                chk("tie_up", int'(up1), 0);
                chk("tie_dn", int'(dn1), 0);
            end
            if (i == 62) chk("early_vote15", int'(vote1), -15);
            if (i == 63) begin
                chk("early_dn", int'(dn1), 1);
                chk("early_up", int'(up1), 0);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pulse_cleared", int'(dn1), 0);

        // Stalls between valid UIs are transparent to the window
        flush();
        nup = 0;
        upidx = -1;
        for (int i = 0; i < 16; i++) begin
            ui(i[0], 1'b1);
            if (up1) begin
                nup++;
                upidx = i;
            end
            repeat ($urandom_range(0, 3)) begin
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (up1) nup++;
            end
        end
        chk("stall_up_count", nup, 1);
        chk("stall_up_index", upidx, 15);

        // Flush at count=10, then a full 16 valid UIs are needed again
        flush();
        for (int i = 0; i < 10; i++) ui(i[0], 1'b1);
        chk("preflush_vote", int'(vote1), 9);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_vote", int'(vote1), 0);
        for (int i = 0; i < 16; i++) begin
            ui(i[0], 1'b1);
            if (i == 14) chk("postflush_no_done", int'(wd1), 0);
        end
        chk("postflush_done", int'(wd1), 1);
        chk("postflush_up", int'(up1), 1);

        // Asynchronous reset mid-window with vote=5
        flush();
        for (int i = 0; i < 6; i++) ui(i[0], 1'b1);
        chk("prereset_vote", int'(vote1), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vote", int'(vote1), 0);
        chk("async_rst_up", int'(up1), 0);
        chk("async_rst_dn", int'(dn1), 0);
        chk("async_rst_win_done", int'(wd1), 0);
        m_vote = 0; m_cnt = 0; m_have = 1'b0; m_dprev = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) ui(i[0], 1'b1);
        chk("postreset_up", int'(up1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
